// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants and types for the frame object sequencer
// Purpose: screen/object geometry, keyboard codes, sequencer state enum and
//          the signed motion type used by the ball axes.
// Contents: SCREEN_W/H, BALL_SIZE, BLOCK_SIZE, BALL_STEP, BLOCK_STEP,
//           KEY_W/A/S/D/P, state_t, motion_t.
package game_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int BALL_SIZE  = 4;
  localparam int BLOCK_SIZE = 8;
  localparam int BALL_STEP  = 1;
  localparam int BLOCK_STEP = 2;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_P = 8'h13;

  typedef enum logic [2:0] {
    IDLE,
    BALL,
    BLOCK,
    COLLIDE,
    COMMIT
  } state_t;

  typedef logic signed [9:0] motion_t;

endpackage

// File: rtl/bounce_axis.sv
// rtl/bounce_axis.sv - one-axis ball step with wall bounce (combinational)
// Purpose: advance a ball coordinate by its motion and reflect it off the
//          walls at size and limit-1-size.
// Ports:
//   pos         in  10  current centre coordinate
//   motion      in  10  signed per-frame motion
//   limit       in  10  screen extent on this axis
//   size        in  10  ball radius
//   next_pos    out 10  stepped and clamped coordinate
//   next_motion out 10  motion for the following frame
module bounce_axis
  import game_pkg::*;
#(
  parameter int STEP = BALL_STEP
) (
  input  logic [9:0] pos,
  input  motion_t    motion,
  input  logic [9:0] limit,
  input  logic [9:0] size,
  output logic [9:0] next_pos,
  output motion_t    next_motion
);

  // 12-bit signed keeps the sum honest below 0 and above 1023, so a step
  // past either wall is caught before it could wrap.
  logic signed [11:0] sum;
  logic signed [11:0] hi;
  logic signed [11:0] lo;

  always_comb begin
    sum         = $signed({2'b00, pos}) + $signed({{2{motion[9]}}, motion});
    lo          = $signed({2'b00, size});
    hi          = $signed({2'b00, limit}) - 12'sd1 - lo;
    next_pos    = sum[9:0];
    next_motion = motion;
    if (sum >= hi) begin
      next_pos    = hi[9:0];
      next_motion = -motion_t'(STEP);
    end else if (sum <= lo) begin
      next_pos    = size;
      next_motion = motion_t'(STEP);
    end
  end

endmodule

// File: rtl/frame_object_sequencer.sv
// rtl/frame_object_sequencer.sv - per-frame ball/block update for color_mapper
// Purpose: on each vs_n falling edge step the ball with wall bounce, move the
//          block from the keycode, test ball/block overlap, then commit every
//          output together so the mapper never sees a half-updated frame.
// Optional: PAUSE_EN adds a P-key toggled pause flag.
// Ports:
//   Clk         in   1  system clock
//   Reset_n     in   1  asynchronous active-low reset
//   vs_n        in   1  vertical sync, active low, synchronous to Clk
//   keycode     in   8  current HID keycode, 0 = none
//   BallX/Y     out 10  ball centre
//   Ball_size   out 10  ball radius (constant)
//   BlockX/Y    out 10  block top-left corner
//   Block_size  out 10  block extent (constant)
//   hit         out  1  one-cycle pulse on a committed collision
//   hit_count   out  8  saturating collision counter
//   busy        out  1  high while the sequencer is not idle
module frame_object_sequencer
  import game_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs_n,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic [9:0] BlockX,
  output logic [9:0] BlockY,
  output logic [9:0] Block_size,
  output logic       hit,
  output logic [7:0] hit_count,
  output logic       busy
);

  localparam logic [9:0] BALL_X0  = 10'(SCREEN_W / 2);
  localparam logic [9:0] BALL_Y0  = 10'(SCREEN_H / 2);
  localparam logic [9:0] BLOCK_X0 = 10'd100;
  localparam logic [9:0] BLOCK_Y0 = 10'd100;
  localparam logic [9:0] LIM_X    = 10'(SCREEN_W);
  localparam logic [9:0] LIM_Y    = 10'(SCREEN_H);
  localparam logic [9:0] BSZ      = 10'(BALL_SIZE);
  localparam logic signed [10:0] BLK_STEP  = 11'(BLOCK_STEP);
  localparam logic signed [10:0] BLK_X_MAX = 11'(SCREEN_W - 1 - BLOCK_SIZE);
  localparam logic signed [10:0] BLK_Y_MAX = 11'(SCREEN_H - 1 - BLOCK_SIZE);
  localparam logic [10:0] OVL_FAR  = 11'(BALL_SIZE + BLOCK_SIZE);
  localparam logic [10:0] OVL_NEAR = 11'(BALL_SIZE);

  assign Ball_size  = BSZ;
  assign Block_size = 10'(BLOCK_SIZE);

  state_t     state, state_nxt;
  logic       vs_prev;
  logic       frame_event;
  logic       paused;
  logic [9:0] ball_x_sh, ball_y_sh, block_x_sh, block_y_sh;
  motion_t    mot_x, mot_y;
  logic       overlap;

  logic [9:0] ball_x_nxt, ball_y_nxt, block_x_nxt, block_y_nxt;
  motion_t    mot_x_nxt, mot_y_nxt;
  logic       ovl_c;
  logic signed [10:0] bxs, bys;

  assign frame_event = vs_prev & ~vs_n;

  bounce_axis #(.STEP(BALL_STEP)) u_bounce_x (
    .pos        (ball_x_sh),
    .motion     (mot_x),
    .limit      (LIM_X),
    .size       (BSZ),
    .next_pos   (ball_x_nxt),
    .next_motion(mot_x_nxt)
  );

  bounce_axis #(.STEP(BALL_STEP)) u_bounce_y (
    .pos        (ball_y_sh),
    .motion     (mot_y),
    .limit      (LIM_Y),
    .size       (BSZ),
    .next_pos   (ball_y_nxt),
    .next_motion(mot_y_nxt)
  );

  // Block move in 11-bit signed so a step left of 0 goes negative and clamps
  // instead of wrapping to the far edge.
  always_comb begin
    bxs = $signed({1'b0, block_x_sh});
    bys = $signed({1'b0, block_y_sh});
    case (keycode)
      KEY_W:   bys = bys - BLK_STEP;
      KEY_S:   bys = bys + BLK_STEP;
      KEY_A:   bxs = bxs - BLK_STEP;
      KEY_D:   bxs = bxs + BLK_STEP;
      default: ;
    endcase
    if (bxs < 11'sd0)          bxs = 11'sd0;
    else if (bxs > BLK_X_MAX)  bxs = BLK_X_MAX;
    if (bys < 11'sd0)          bys = 11'sd0;
    else if (bys > BLK_Y_MAX)  bys = BLK_Y_MAX;
    block_x_nxt = bxs[9:0];
    block_y_nxt = bys[9:0];
  end

  // Boxes [ball-R, ball+R] and [blk, blk+S] meet when ball <= blk+R+S and
  // blk <= ball+R; rearranged this way nothing needs to go negative.
  always_comb begin
    ovl_c = ({1'b0, ball_x_sh} <= {1'b0, block_x_sh} + OVL_FAR) &&
            ({1'b0, block_x_sh} <= {1'b0, ball_x_sh} + OVL_NEAR) &&
            ({1'b0, ball_y_sh} <= {1'b0, block_y_sh} + OVL_FAR) &&
            ({1'b0, block_y_sh} <= {1'b0, ball_y_sh} + OVL_NEAR);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_event) state_nxt = BALL;
      end
      BALL:    state_nxt = BLOCK;
      BLOCK:   state_nxt = COLLIDE;
      COLLIDE: state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PAUSE_EN
  logic [7:0] key_prev;

  // Toggle only on a new P press seen at an accepted frame event, so a held
  // key flips the flag once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      paused   <= 1'b0;
      key_prev <= 8'h00;
    end else if (state == IDLE && frame_event) begin
      key_prev <= keycode;
      if (keycode == KEY_P && keycode != key_prev) paused <= ~paused;
    end
  end
`else
  assign paused = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_prev    <= 1'b1;
      ball_x_sh  <= BALL_X0;
      ball_y_sh  <= BALL_Y0;
      mot_x      <= motion_t'(BALL_STEP);
      mot_y      <= motion_t'(BALL_STEP);
      block_x_sh <= BLOCK_X0;
      block_y_sh <= BLOCK_Y0;
      overlap    <= 1'b0;
      BallX      <= BALL_X0;
      BallY      <= BALL_Y0;
      BlockX     <= BLOCK_X0;
      BlockY     <= BLOCK_Y0;
      hit        <= 1'b0;
      hit_count  <= 8'd0;
    end else begin
      vs_prev <= vs_n;
      hit     <= 1'b0;
      case (state)
        BALL: begin
          if (!paused) begin
            ball_x_sh <= ball_x_nxt;
            ball_y_sh <= ball_y_nxt;
            mot_x     <= mot_x_nxt;
            mot_y     <= mot_y_nxt;
          end
        end
        BLOCK: begin
          if (!paused) begin
            block_x_sh <= block_x_nxt;
            block_y_sh <= block_y_nxt;
          end
        end
        COLLIDE: begin
          // Reflection takes effect next frame; this frame's shadows stand.
          overlap <= ovl_c & ~paused;
          if (ovl_c && !paused) begin
            mot_x <= -mot_x;
            mot_y <= -mot_y;
          end
        end
        COMMIT: begin
          BallX  <= ball_x_sh;
          BallY  <= ball_y_sh;
          BlockX <= block_x_sh;
          BlockY <= block_y_sh;
          if (overlap) begin
            hit <= 1'b1;
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_object_sequencer.sv
// tb/tb_frame_object_sequencer.sv - randomized self-checking bench for frame_object_sequencer
module tb_frame_object_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       vs_n = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic [9:0] BallX, BallY, Ball_size, BlockX, BlockY, Block_size;
  logic       hit;
  logic [7:0] hit_count;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: ball centre/motion, block corner, collision count.
  int m_bx, m_by, m_mx, m_my, m_kx, m_ky, m_hc;

  logic [7:0] keys [7] = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h05, 8'hFF};

  frame_object_sequencer dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .vs_n      (vs_n),
    .keycode   (keycode),
    .BallX     (BallX),
    .BallY     (BallY),
    .Ball_size (Ball_size),
    .BlockX    (BlockX),
    .BlockY    (BlockY),
    .Block_size(Block_size),
    .hit       (hit),
    .hit_count (hit_count),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bx = 320; m_by = 240; m_mx = 1; m_my = 1;
    m_kx = 100; m_ky = 100; m_hc = 0;
  endtask

  // One whole frame of game rules on plain integers.
  task automatic model_frame(input logic [7:0] key, output bit ov);
    m_bx = m_bx + m_mx;
    if (m_bx + 4 >= 639) begin m_bx = 635; m_mx = -1; end
    else if (m_bx <= 4) begin m_bx = 4; m_mx = 1; end
    m_by = m_by + m_my;
    if (m_by + 4 >= 479) begin m_by = 475; m_my = -1; end
    else if (m_by <= 4) begin m_by = 4; m_my = 1; end
    case (key)
      8'h1A: m_ky = m_ky - 2;
      8'h16: m_ky = m_ky + 2;
      8'h04: m_kx = m_kx - 2;
      8'h07: m_kx = m_kx + 2;
      default: ;
    endcase
    if (m_kx < 0) m_kx = 0;
    if (m_kx > 631) m_kx = 631;
    if (m_ky < 0) m_ky = 0;
    if (m_ky > 471) m_ky = 471;
    ov = (m_bx - 4 <= m_kx + 8) && (m_kx <= m_bx + 4) &&
         (m_by - 4 <= m_ky + 8) && (m_ky <= m_by + 4);
    if (ov) begin
      m_mx = -m_mx;
      m_my = -m_my;
      if (m_hc < 255) m_hc++;
    end
  endtask

  task automatic check_outputs();
    chk("BallX", BallX, m_bx);
    chk("BallY", BallY, m_by);
    chk("BlockX", BlockX, m_kx);
    chk("BlockY", BlockY, m_ky);
    chk("hit_count", hit_count, m_hc);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_frame(input logic [7:0] key, input bit second_edge);
    bit ov;
    int old_bx, busy_cnt, hit_cnt;
    old_bx = m_bx;
    model_frame(key, ov);
    keycode = key;
    vs_n = 1'b0;
    @(posedge Clk); #1;
    vs_n = 1'b1;
    busy_cnt = 0;
    hit_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (second_edge && c == 1) vs_n = 1'b0;
      if (second_edge && c == 2) vs_n = 1'b1;
      @(negedge Clk);
      if (busy) busy_cnt++;
      if (hit) hit_cnt++;
      if (c == 4) chk("BallX_before_commit", BallX, old_bx);
      @(posedge Clk); #1;
    end
    chk("busy_cycles", busy_cnt, 4);
    chk("hit_cycles", hit_cnt, ov ? 1 : 0);
    check_outputs();
  endtask

  task automatic check_reset_values();
    chk("rst_BallX", BallX, 320);
    chk("rst_BallY", BallY, 240);
    chk("rst_BlockX", BlockX, 100);
    chk("rst_BlockY", BlockY, 100);
    chk("rst_hit", hit, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    bit   ov;
    logic [7:0] k;
    int   dx, dy, adx, ady;

    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_reset_values();
    chk("Ball_size", Ball_size, 4);
    chk("Block_size", Block_size, 8);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // First frame, then a frame with a second edge while busy.
    run_frame(8'h00, 1'b0);
    run_frame(8'h00, 1'b1);
    chk("dropped_edge_BallX", BallX, 322);

    // Idle frames carry the ball into the right and bottom walls.
    for (int f = 0; f < 330; f++) run_frame(8'h00, 1'b0);

    // Drive the block into the left/top edges and hold it there.
    for (int f = 0; f < 55; f++) run_frame(8'h04, 1'b0);
    chk("block_left_edge", BlockX, 0);
    for (int f = 0; f < 55; f++) run_frame(8'h1A, 1'b0);
    chk("block_top_edge", BlockY, 0);

    // Mixed random keys and ball-chasing phases to provoke collisions.
    for (int p = 0; p < 20; p++) begin
      bit chase;
      chase = ($urandom_range(0, 1) == 1);
      for (int f = 0; f < 32; f++) begin
        if (chase) begin
          dx = m_bx - (m_kx + 4);
          dy = m_by - (m_ky + 4);
          adx = (dx < 0) ? -dx : dx;
          ady = (dy < 0) ? -dy : dy;
          if (adx > ady) k = (dx > 0) ? 8'h07 : 8'h04;
          else           k = (dy > 0) ? 8'h16 : 8'h1A;
        end else begin
          k = keys[$urandom_range(0, 6)];
        end
        run_frame(k, 1'b0);
        repeat ($urandom_range(0, 3)) @(posedge Clk);
        #1;
      end
    end

    // Reset while the sequencer sits in COLLIDE.
    keycode = 8'h07;
    vs_n = 1'b0;
    @(posedge Clk); #1;
    vs_n = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("busy_in_collide", busy, 1);
    Reset_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      chk("post_reset_hit", hit, 0);
    end
    @(posedge Clk); #1;
    check_outputs();
    run_frame(8'h00, 1'b0);
    chk("post_reset_frame_BallX", BallX, 321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
